// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a byte-lane data memory.
// Halfword accesses are split into two byte accesses (low byte at adr, high byte at adr+1).
module mem_access_unit (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_adr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misalign,
   output logic        busy,
   output logic        dm_WrEn,
   output logic        dm_RdEn,
   output logic        dm_B,
   output logic        dm_LB,
   output logic [31:0] dm_Adr,
   output logic [31:0] dm_DataIn,
   input  logic [31:0] dm_DataOut
);

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b010;
   localparam logic [2:0] OP_LH  = 3'b011;
   localparam logic [2:0] OP_LHU = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b110;
   localparam logic [2:0] OP_SH  = 3'b111;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  lo_q, lo_d;
   logic [31:0] result_q, result_d;
   logic        mis_q, mis_d;

   logic        req_mis;
   logic        op_is_half;
   logic        op_is_store;
   logic        in_acc;
   logic [7:0]  hi_byte;

   always_comb begin
      req_mis = 1'b0;
      case (req_op)
         OP_LW, OP_SW:         req_mis = (req_adr[1:0] != 2'b00);
         OP_LH, OP_LHU, OP_SH: req_mis = req_adr[0];
         default:              req_mis = 1'b0;
      endcase
   end

   assign op_is_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
   assign op_is_store = (op_q == OP_SW) || (op_q == OP_SB) || (op_q == OP_SH);
   assign in_acc      = (state_q == ACC0) || (state_q == ACC1);
   assign hi_byte     = dm_DataOut[7:0];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      adr_d    = adr_q;
      wdata_d  = wdata_q;
      lo_d     = lo_q;
      result_d = result_q;
      mis_d    = mis_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d     = req_op;
               adr_d    = req_adr;
               wdata_d  = req_wdata;
               result_d = 32'd0;
               mis_d    = req_mis;
               state_d  = req_mis ? RESP : ACC0;
            end
         end
         ACC0: begin
            if (op_is_half) begin
               lo_d    = dm_DataOut[7:0];
               state_d = ACC1;
            end else begin
               // Byte loads come back already extended by the memory (dm_LB).
               if (!op_is_store) result_d = dm_DataOut;
               state_d = RESP;
            end
         end
         ACC1: begin
            if (op_q == OP_LH)       result_d = {{16{hi_byte[7]}}, hi_byte, lo_q};
            else if (op_q == OP_LHU) result_d = {16'd0, hi_byte, lo_q};
            else                     result_d = 32'd0;
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         op_q     <= 3'd0;
         adr_q    <= 32'd0;
         wdata_q  <= 32'd0;
         lo_q     <= 8'd0;
         result_q <= 32'd0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         adr_q    <= adr_d;
         wdata_q  <= wdata_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         mis_q    <= mis_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = (state_q == RESP) ? result_q : 32'd0;
   assign misalign   = (state_q == RESP) && mis_q;

   // Enables are qualified by Rst_n so a reset landing in an access cycle
   // prevents that access from committing at the same edge.
   assign dm_RdEn = in_acc && !op_is_store && Rst_n;
   assign dm_WrEn = in_acc && op_is_store && Rst_n;
   assign dm_B    = in_acc && (op_q != OP_LW) && (op_q != OP_SW);
   assign dm_LB   = in_acc && (op_q == OP_LB);

   always_comb begin
      dm_Adr    = 32'd0;
      dm_DataIn = 32'd0;
      if (in_acc) begin
         dm_Adr = (state_q == ACC1) ? adr_q + 32'd1 : adr_q;
         if (op_is_store) begin
            if (op_q == OP_SW)          dm_DataIn = wdata_q;
            else if (state_q == ACC1)   dm_DataIn = {24'd0, wdata_q[15:8]};
            else                        dm_DataIn = {24'd0, wdata_q[7:0]};
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-lane memory model, scoreboard of expected
// responses (data, misalign flag, response cycle) and directed load/store sequence.
module tb_mem_access_unit;

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b010;
   localparam logic [2:0] OP_LH  = 3'b011;
   localparam logic [2:0] OP_LHU = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b110;
   localparam logic [2:0] OP_SH  = 3'b111;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_adr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misalign;
   logic        busy;
   logic        dm_WrEn, dm_RdEn, dm_B, dm_LB;
   logic [31:0] dm_Adr, dm_DataIn, dm_DataOut;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int strobe_cnt = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      int          at_cyc;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] wr_adr_q[$];
   logic [31:0] wr_dat_q[$];
   logic        wr_b_q[$];

   logic [7:0]  mem [0:255];
   logic [7:0]  rd_byte;
   logic [7:0]  a8;

   mem_access_unit dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_adr(req_adr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign(misalign),
      .busy(busy),
      .dm_WrEn(dm_WrEn), .dm_RdEn(dm_RdEn), .dm_B(dm_B), .dm_LB(dm_LB),
      .dm_Adr(dm_Adr), .dm_DataIn(dm_DataIn), .dm_DataOut(dm_DataOut)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Little-endian byte lanes; byte mode extends according to dm_LB.
   always_comb begin
      a8 = dm_Adr[7:0];
      rd_byte = mem[a8];
      if (dm_B)
         dm_DataOut = dm_LB ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      else
         dm_DataOut = {mem[{a8[7:2], 2'd3}], mem[{a8[7:2], 2'd2}],
                       mem[{a8[7:2], 2'd1}], mem[{a8[7:2], 2'd0}]};
   end

   always @(posedge Clk) begin
      if (dm_WrEn) begin
         if (dm_B) begin
            mem[dm_Adr[7:0]] <= dm_DataIn[7:0];
         end else begin
            mem[{dm_Adr[7:2], 2'd0}] <= dm_DataIn[7:0];
            mem[{dm_Adr[7:2], 2'd1}] <= dm_DataIn[15:8];
            mem[{dm_Adr[7:2], 2'd2}] <= dm_DataIn[23:16];
            mem[{dm_Adr[7:2], 2'd3}] <= dm_DataIn[31:24];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Response monitor: every resp_valid must match the oldest expected entry.
   always @(negedge Clk) begin
      if (dm_WrEn || dm_RdEn) strobe_cnt++;
      if (dm_WrEn) begin
         wr_adr_q.push_back(dm_Adr);
         wr_dat_q.push_back(dm_DataIn);
         wr_b_q.push_back(dm_B);
      end
      if (resp_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_misalign", {31'd0, misalign}, {31'd0, e.mis});
            chk("resp_cycle", cyc, e.at_cyc);
            $display("resp: rdata=0x%08h misalign=%0b cycle=%0d", resp_rdata, misalign, cyc);
         end
      end
   end

   task automatic do_req(input logic [2:0] op, input logic [31:0] adr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_mis, input bit push);
      int n;
      int delta;
      exp_t e;
      @(negedge Clk);
      req_valid = 1'b1;
      req_op    = op;
      req_adr   = adr;
      req_wdata = wdata;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
      if (exp_mis)                                           delta = 0;
      else if (op == OP_LH || op == OP_LHU || op == OP_SH)   delta = 2;
      else                                                   delta = 1;
      if (push) begin
         e.rdata  = exp_rdata;
         e.mis    = exp_mis;
         e.at_cyc = cyc + 1 + delta;
         sb_q.push_back(e);
      end
      $display("req: op=%0d adr=0x%08h wdata=0x%08h", op, adr, wdata);
      @(posedge Clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 50) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic clear_log();
      wr_adr_q.delete();
      wr_dat_q.delete();
      wr_b_q.delete();
   endtask

   initial begin
      int s0;
      Rst_n     = 1'b0;
      req_valid = 1'b1;
      req_op    = OP_SW;
      req_adr   = 32'h40;
      req_wdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      chk("rst_strobes", {28'd0, dm_WrEn, dm_RdEn, dm_B, dm_LB}, 32'd0);
      chk("rst_dm_adr", dm_Adr, 32'd0);
      chk("rst_dm_datain", dm_DataIn, 32'd0);
      chk("rst_strobe_cnt", strobe_cnt, 32'd0);
      req_valid = 1'b0;
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // Word store then load
      clear_log();
      do_req(OP_SW, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
      drain();
      chk("sw_wr_count", wr_adr_q.size(), 32'd1);
      if (wr_adr_q.size() == 1) begin
         chk("sw_wr_adr", wr_adr_q[0], 32'h10);
         chk("sw_wr_data", wr_dat_q[0], 32'hDEADBEEF);
         chk("sw_wr_b", {31'd0, wr_b_q[0]}, 32'd0);
      end
      do_req(OP_LW, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
      drain();

      // Byte store and signed/unsigned byte loads
      do_req(OP_SB, 32'h13, 32'h0000_0080, 32'd0, 1'b0, 1'b1);
      do_req(OP_LW, 32'h10, 32'd0, 32'h80ADBEEF, 1'b0, 1'b1);
      do_req(OP_LB, 32'h13, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b1);
      do_req(OP_LBU, 32'h13, 32'd0, 32'h0000_0080, 1'b0, 1'b1);
      drain();

      // Halfword store split into two byte writes, then halfword loads
      do_req(OP_SW, 32'h20, 32'h0000_0000, 32'd0, 1'b0, 1'b1);
      drain();
      clear_log();
      do_req(OP_SH, 32'h22, 32'h12348001, 32'd0, 1'b0, 1'b1);
      drain();
      chk("sh_wr_count", wr_adr_q.size(), 32'd2);
      if (wr_adr_q.size() == 2) begin
         chk("sh_wr0_adr", wr_adr_q[0], 32'h22);
         chk("sh_wr0_data", wr_dat_q[0], 32'h01);
         chk("sh_wr0_b", {31'd0, wr_b_q[0]}, 32'd1);
         chk("sh_wr1_adr", wr_adr_q[1], 32'h23);
         chk("sh_wr1_data", wr_dat_q[1], 32'h80);
      end
      do_req(OP_LH, 32'h22, 32'd0, 32'hFFFF_8001, 1'b0, 1'b1);
      do_req(OP_LHU, 32'h22, 32'd0, 32'h0000_8001, 1'b0, 1'b1);
      drain();

      // Misaligned requests never touch memory
      s0 = strobe_cnt;
      do_req(OP_LW, 32'h06, 32'd0, 32'd0, 1'b1, 1'b1);
      do_req(OP_SH, 32'h21, 32'h0000_FFFF, 32'd0, 1'b1, 1'b1);
      drain();
      chk("mis_no_strobe", strobe_cnt, s0);
      do_req(OP_LW, 32'h20, 32'd0, 32'h80010000, 1'b0, 1'b1);
      drain();

      // Reset during the second byte of a halfword store
      do_req(OP_SW, 32'h30, 32'h11225A00, 32'd0, 1'b0, 1'b1);
      drain();
      do_req(OP_SH, 32'h30, 32'h0000_AABB, 32'd0, 1'b0, 1'b0);
      @(negedge Clk);
      @(negedge Clk);
      chk("acc1_wren", {31'd0, dm_WrEn}, 32'd1);
      chk("acc1_adr", dm_Adr, 32'h31);
      Rst_n = 1'b0;
      @(negedge Clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ready", {31'd0, req_ready}, 32'd1);
      chk("midrst_resp", {31'd0, resp_valid}, 32'd0);
      Rst_n = 1'b1;
      chk("midrst_byte30", {24'd0, mem[8'h30]}, 32'hBB);
      chk("midrst_byte31", {24'd0, mem[8'h31]}, 32'h5A);
      do_req(OP_LW, 32'h30, 32'd0, 32'h11225ABB, 1'b0, 1'b1);
      drain();

      repeat (3) @(negedge Clk);
      chk("sb_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the pipeline MEM stage and the data memory. Accepts one request at a time (LW/LB/LBU/LH/LHU/SW/SB/SH) and drives the data memory's word/byte port (write enable, read enable, byte-mode, sign-extend-byte, address, write data). Halfword operations are split into two sequential byte accesses. The unit returns a single-cycle response with the assembled load data or a misalignment flag.

## Interface
- No parameters; data memory port fixed at 32-bit address and data, with byte lane = Adr[1:0].
- Clk  input  1  single clock; all state changes on rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; request accepted on an edge where req_valid & req_ready.
- req_op  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH.
- req_adr  input  32  byte address.
- req_wdata  input  32  store data (SB uses [7:0], SH uses [15:0]).
- resp_valid  output  1  one-cycle pulse when the request completes.
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and misaligned requests.
- misalign  output  1  valid with resp_valid; request was misaligned and not executed.
- busy  output  1  state != IDLE.
- dm_WrEn, dm_RdEn, dm_B, dm_LB  output  1 each  data memory strobes (B=1 byte mode, LB=1 sign-extend byte).
- dm_Adr  output  32  data memory address.
- dm_DataIn  output  32  data memory write data.
- dm_DataOut  input  32  data memory combinational read data.

## Operation
- States: IDLE, ACC0, ACC1, RESP. Request address, op and data are registered on acceptance.
- IDLE -> RESP if misaligned: LW/SW with adr[1:0]!=0, LH/LHU/SH with adr[0]!=0. No DM strobe is ever raised. RESP then reports misalign=1 and rdata=0.
- IDLE -> ACC0 otherwise. In ACC0 the DM strobes are driven from the registered request.
  - LW: RdEn=1, B=0. LB: RdEn=1, B=1, LB=1. LBU/LH/LHU: RdEn=1, B=1, LB=0.
  - SW: WrEn=1, B=0, DataIn=wdata. SB/SH: WrEn=1, B=1, DataIn={24'b0, wdata[7:0]}.
  - dm_Adr = registered adr.
- Load data is captured from dm_DataOut at the end of the access cycle. Stores commit at that same edge.
- ACC0 -> RESP for word and byte ops. ACC0 -> ACC1 for halfword ops.
- ACC0 of a halfword uses the low byte at adr. ACC1 uses adr+1 with the same strobes.
  - SH: ACC1 DataIn={24'b0, wdata[15:8]}.
  - LH/LHU: the ACC0 capture is the low byte; the ACC1 capture is the high byte.
  - Result = {16{hi[7]}, hi, lo} for LH and {16'b0, hi, lo} for LHU.
- The halfword's adr[0]=0 guarantees that adr+1 stays in the same word.
- RESP: resp_valid=1 for one cycle, then -> IDLE. There is no response backpressure.
- DM strobes are 0 in IDLE and RESP. dm_Adr and dm_DataIn are 0 outside ACC states.
- No range check; address bits above the memory size pass through unchanged.

## Timing
- Reset values (cycle after any edge with Rst_n=0): state IDLE, req_ready=1, busy=0, resp_valid=0, resp_rdata=0, misalign=0, all dm_* outputs 0.
- Latency from the acceptance edge to resp_valid high:
  - Word/byte: 2 cycles (ACC0, RESP).
  - Halfword: 3 cycles (ACC0, ACC1, RESP).
  - Misaligned: 1 cycle.
- Throughput: the next request can be accepted in the cycle after RESP. req_ready=0 from acceptance through RESP inclusive.
- req_valid while busy is ignored, not queued. The requester must hold the request until req_ready.
- Reset mid-operation has priority over all transitions; state is IDLE at the next edge.
  - Reset during ACC1 of SH: the second byte is not written, and the already-committed low byte stays in memory.
  - A reset in any state suppresses the pending response.

## Test plan
- Hold Rst_n=0 for 2 cycles with req_valid=1 -> all outputs at reset values, no DM strobe. After release, req_ready=1.
- SW adr 0x10, wdata 0xDEADBEEF, then LW 0x10 -> one WrEn cycle, B=0. The LW response is 0xDEADBEEF two cycles after acceptance, misalign=0.
- SB adr 0x13, wdata 0x00000080 -> word 0x10 reads 0x80ADBEEF. LB 0x13 -> 0xFFFFFF80. LBU 0x13 -> 0x00000080.
- SH adr 0x22, wdata 0x12348001 -> WrEn at 0x22 with DataIn 0x01, then at 0x23 with 0x80. LH 0x22 -> 0xFFFF8001 and LHU -> 0x00008001, each 3 cycles after acceptance.
- LW adr 0x06 and SH adr 0x21 -> resp_valid the cycle after acceptance with misalign=1, rdata=0. WrEn and RdEn never asserted; memory unchanged.
- SH adr 0x30, wdata 0xAABB, with Rst_n=0 during ACC1 -> byte 0x30=0xBB, byte 0x31 unchanged, no resp_valid, next cycle IDLE with req_ready=1.
